// File: rtl/router_fsm_if.sv
// ============================================================================
// Module      : router_fsm_if
// Description : Source, register-block and synchronizer signals seen by the
//               router sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface router_fsm_if #(
    parameter int NUM_DEST = 3,
    parameter int ADDR_W   = 2,
    parameter int CNT_W    = 8
);
    logic                pkt_valid;
    logic [ADDR_W-1:0]   data_in;
    logic                fifo_full;
    logic [NUM_DEST-1:0] fifo_empty;
    logic [NUM_DEST-1:0] soft_reset;
    logic                parity_done;
    logic                low_packet_valid;

    logic                detect_addr;
    logic                lfd_state;
    logic                ld_state;
    logic                full_state;
    logic                laf_state;
    logic                rst_int_reg;
    logic                write_enb_reg;
    logic                busy;
    logic [ADDR_W-1:0]   dest_sel;
    logic [CNT_W-1:0]    drop_cnt;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        input  detect_addr, lfd_state, ld_state, full_state, laf_state,
               rst_int_reg, write_enb_reg, busy, dest_sel, drop_cnt
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        output detect_addr, lfd_state, ld_state, full_state, laf_state,
               rst_int_reg, write_enb_reg, busy, dest_sel, drop_cnt
    );
endinterface

`default_nettype wire

// File: rtl/router_fsm.sv
// ============================================================================
// Module      : router_fsm
// Description : Sequencing controller for the 1x3 router: header decode,
//               load sequencing, FIFO write gating and source back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_fsm #(
    parameter int NUM_DEST = 3,
    parameter int ADDR_W   = 2,
    parameter int CNT_W    = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    router_fsm_if.slave bus
);

    localparam logic [ADDR_W:0] c_num_dest = (ADDR_W+1)'(NUM_DEST);

    typedef enum logic [2:0] {
        S_DECODE_ADDRESS     = 3'd0,
        S_WAIT_TILL_EMPTY    = 3'd1,
        S_LOAD_FIRST_DATA    = 3'd2,
        S_LOAD_DATA          = 3'd3,
        S_FIFO_FULL_STATE    = 3'd4,
        S_LOAD_AFTER_FULL    = 3'd5,
        S_LOAD_PARITY        = 3'd6,
        S_CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_dest_sel;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic              r_pkt_valid_d;

    logic              w_addr_legal;
    logic              w_hdr_empty;
    logic              w_sel_soft_reset;
    logic              w_load_dest;
    logic              w_drop_inc;

    assign w_addr_legal     = ({1'b0, bus.data_in} < c_num_dest);
    assign w_hdr_empty      = bus.fifo_empty[bus.data_in];
    assign w_sel_soft_reset = bus.soft_reset[r_dest_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_DECODE_ADDRESS;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_load_dest       = 1'b0;
        w_drop_inc        = 1'b0;
        bus.detect_addr   = 1'b0;
        bus.lfd_state     = 1'b0;
        bus.ld_state      = 1'b0;
        bus.full_state    = 1'b0;
        bus.laf_state     = 1'b0;
        bus.rst_int_reg   = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.busy          = 1'b1;

        case (r_state)
            S_DECODE_ADDRESS: begin
                bus.detect_addr = 1'b1;
                bus.busy        = 1'b0;
                if (bus.pkt_valid && w_addr_legal) begin
                    w_load_dest  = 1'b1;
                    w_next_state = w_hdr_empty ? S_LOAD_FIRST_DATA : S_WAIT_TILL_EMPTY;
                end else if (bus.pkt_valid && !r_pkt_valid_d) begin
                    // Illegal header: count once per packet on the pkt_valid rising edge
                    w_drop_inc = 1'b1;
                end
            end
            S_WAIT_TILL_EMPTY: begin
                if (bus.fifo_empty[r_dest_sel]) w_next_state = S_LOAD_FIRST_DATA;
            end
            S_LOAD_FIRST_DATA: begin
                bus.lfd_state = 1'b1;
                w_next_state  = S_LOAD_DATA;
            end
            S_LOAD_DATA: begin
                bus.ld_state      = 1'b1;
                bus.write_enb_reg = 1'b1;
                bus.busy          = 1'b0;
                if (bus.fifo_full)       w_next_state = S_FIFO_FULL_STATE;
                else if (!bus.pkt_valid) w_next_state = S_LOAD_PARITY;
            end
            S_FIFO_FULL_STATE: begin
                bus.full_state = 1'b1;
                if (!bus.fifo_full) w_next_state = S_LOAD_AFTER_FULL;
            end
            S_LOAD_AFTER_FULL: begin
                bus.laf_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
                if (bus.parity_done)           w_next_state = S_DECODE_ADDRESS;
                else if (bus.low_packet_valid) w_next_state = S_LOAD_PARITY;
                else                           w_next_state = S_LOAD_DATA;
            end
            S_LOAD_PARITY: begin
                bus.write_enb_reg = 1'b1;
                w_next_state      = S_CHECK_PARITY_ERROR;
            end
            S_CHECK_PARITY_ERROR: begin
                bus.rst_int_reg = 1'b1;
                w_next_state    = bus.fifo_full ? S_FIFO_FULL_STATE : S_DECODE_ADDRESS;
            end
            default: begin
                w_next_state = S_DECODE_ADDRESS;
            end
        endcase

        // A read timeout on the selected port aborts the packet from any active state
        if (r_state != S_DECODE_ADDRESS && w_sel_soft_reset) begin
            w_next_state = S_DECODE_ADDRESS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dest_sel    <= '0;
            r_drop_cnt    <= '0;
            r_pkt_valid_d <= 1'b0;
        end else begin
            r_pkt_valid_d <= bus.pkt_valid;
            if (w_load_dest) begin
                r_dest_sel <= bus.data_in;
            end
            if (w_drop_inc && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.dest_sel = r_dest_sel;
    assign bus.drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire
